cmult_stream: RTL and testbench
===============================

Name: cmult_stream

Overview:
- Streaming, fully pipelined complex multiplier p = a * b (or a * conj(b)).
- Uses the shared-term 3-multiplier form with valid/ready flow control.
- Rounds and saturates the output to a configurable width, and carries a sticky overflow flag.
- Successor to the fixed-width free-running complex multiplier; used in the PFB twiddle and phase-rotation paths where downstream can stall.

Parameters:
- AWIDTH, 16, signed width of ar/ai
- BWIDTH, 18, signed width of br/bi
- OUT_WIDTH, 16, signed width of pr/pi
- SHIFT, 17, LSBs discarded by rounding; 0 disables rounding
- LAT, 6, pipeline depth in cycles; fixed, documented, not otherwise settable

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept input this cycle
- s_last  in  1  frame marker, carried alongside data
- conj  in  1  per-sample: 1 selects a*conj(b); sampled with data
- ar, ai  in  AWIDTH  signed operand a
- br, bi  in  BWIDTH  signed operand b
- m_valid  out  1  output valid
- m_ready  in  1  downstream accepts
- m_last  out  1  s_last delayed with its sample
- pr, pi  out  OUT_WIDTH  signed result
- ovf  out  1  sticky saturation flag
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:

Reset:
- Reset is asynchronous and active-high; clock is clk.
- While rst=1: m_valid=0, m_last=0, pr=pi=0, ovf=0, all stage valid bits 0.
- s_ready=1 after reset, since the pipeline is empty.

Flow control:
- ce = !m_valid || m_ready.
- s_ready = ce (combinational).
- Every stage register advances only when ce=1.
- Input transfer when s_valid && s_ready; output transfer when m_valid && m_ready.
- A per-stage valid bit travels with the data. Bubbles propagate, so a stage with valid=0 still shifts when ce=1.
- Latency is exactly LAT=6 cycles from input transfer to m_valid when unstalled.
- Throughput is 1 sample per cycle.
- While stalled, pr/pi/m_last are held stable.

Pipeline (each step one register stage):
1. Register inputs. bi' = conj ? -bi : bi, held in BWIDTH+1 bits so -min is exact.
2. Pre-adds:
   - c = ar - ai (AWIDTH+1)
   - dr = br - bi' (BWIDTH+2)
   - di = br + bi' (BWIDTH+2)
3. Multiplies:
   - m0 = c * bi'
   - mr = dr * ar
   - mi = di * ai
   - Full width W = AWIDTH+BWIDTH+3.
4. Post-adds: Pr = mr + m0, Pi = mi + m0, in W bits (exact, no wrap).
5. Rounding: add 2^(SHIFT-1) when SHIFT>0. This is round-half-up, i.e. toward +inf on ties.
6. Shift and saturate:
   - Arithmetic shift right by SHIFT.
   - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
   - Register into pr/pi along with a per-sample sat bit (OR of real/imag saturation).

Overflow flag:
- ovf is set on the cycle an output with sat=1 transfers.
- ovf_clr=1 clears ovf.
- Set and clear in the same cycle: set wins.

Other rules:
- conj and s_last are sampled only on input transfer.
- Reset mid-stream discards all in-flight samples; there is no partial output after rst falls.

Elaboration checks:
- SHIFT < W and OUT_WIDTH <= W-SHIFT, else fatal error.

Decomposition:
- Package cmult_pkg holds:
  - function full_width(AWIDTH, BWIDTH)
  - function sat_max(OUT_WIDTH) and sat_min(OUT_WIDTH)
  - localparam LAT=6
- One sub-module, round_sat: parametrised (IN_W, SHIFT, OUT_W). It is a two-register stage (steps 5-6) with ce, producing the result and sat. It is instantiated twice, for real and imaginary.

Test Plan:
1. SHIFT=0, OUT_WIDTH=37, conj=0, a=3+4i, b=5+6i -> pr=-9, pi=38 exactly 6 cycles later, m_valid one cycle.
2. Same operands with conj=1 -> pr=39, pi=2. Alternate conj every sample over 8 samples -> each result matches its own conj bit.
3. Defaults, conj=0:
   - a=-32768+0i, b=-131072+0i (product 2^32) -> pr=32767, pi=0, ovf=1.
   - Pulse ovf_clr -> ovf=0.
   - ovf_clr coincident with a new saturating output -> ovf stays 1.
4. Defaults, rounding:
   - a=3+0i, b=32768+0i (Pr=98304) -> pr=1.
   - a=-2+0i, b=32768+0i (Pr=-65536, exact -0.5) -> pr=0.
   - a=1+0i, b=32768+0i (Pr=32768) -> pr=0.
5. Stream 20 samples with random m_ready (50%) and random s_valid gaps:
   - outputs are in order and bit-exact against the model;
   - no sample is lost or duplicated;
   - pr/pi/m_last are held stable while stalled;
   - m_last is aligned to sample 20.
6. Assert rst for 1 cycle with 4 samples in flight -> m_valid=0 immediately, no stale outputs afterwards. The first new sample emerges 6 cycles after its transfer.

Source files
------------

// File: rtl/cmult_pkg.sv
// Shared constants and helpers for the streaming complex multiplier.
// Provides pipeline depth, full product width and saturation bounds.
package cmult_pkg;

    localparam int LAT = 6;

    function automatic int full_width(input int aw, input int bw);
        return aw + bw + 3;
    endfunction

    function automatic longint sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

endpackage

// File: rtl/cmult_if.sv
// Stream bundle for cmult_stream: input handshake + operands,
// output handshake + result, sticky overflow flag and its clear.
// master = producer/consumer side, slave = multiplier side.
interface cmult_if #(
    parameter int AWIDTH    = 16,
    parameter int BWIDTH    = 18,
    parameter int OUT_WIDTH = 16
);
    logic                        s_valid;
    logic                        s_ready;
    logic                        s_last;
    logic                        conj;
    logic signed [AWIDTH-1:0]    ar;
    logic signed [AWIDTH-1:0]    ai;
    logic signed [BWIDTH-1:0]    br;
    logic signed [BWIDTH-1:0]    bi;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_last;
    logic signed [OUT_WIDTH-1:0] pr;
    logic signed [OUT_WIDTH-1:0] pi;
    logic                        ovf;
    logic                        ovf_clr;

    modport master (
        output s_valid, s_last, conj, ar, ai, br, bi,
        output m_ready, ovf_clr,
        input  s_ready, m_valid, m_last, pr, pi, ovf
    );

    modport slave (
        input  s_valid, s_last, conj, ar, ai, br, bi,
        input  m_ready, ovf_clr,
        output s_ready, m_valid, m_last, pr, pi, ovf
    );

endinterface

// File: rtl/round_sat.sv
// Two-register round/shift/saturate stage with clock enable.
// Ports: i_clk, i_rst, i_ce, i_d (IN_W) -> o_q (OUT_W), o_sat.
module round_sat
    import cmult_pkg::*;
#(
    parameter int IN_W  = 37,
    parameter int SHIFT = 17,
    parameter int OUT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_ce,
    input  logic signed [IN_W-1:0]  i_d,
    output logic signed [OUT_W-1:0] o_q,
    output logic                    o_sat
);
    // One guard bit so the rounding add can never wrap.
    localparam int RW = IN_W + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << RS) : '0;
    localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OUT_W));
    localparam logic signed [RW-1:0] MINV = RW'(sat_min(OUT_W));

    logic signed [RW-1:0] r_rnd;
    logic signed [RW-1:0] w_sh;
    logic                 w_hi;
    logic                 w_lo;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rnd <= '0;
        end else if (i_ce) begin
            r_rnd <= RW'(i_d) + RND;
        end
    end

    assign w_sh = r_rnd >>> SHIFT;
    assign w_hi = w_sh > MAXV;
    assign w_lo = w_sh < MINV;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q   <= '0;
            o_sat <= 1'b0;
        end else if (i_ce) begin
            o_q   <= w_hi ? OUT_W'(MAXV) :
                     w_lo ? OUT_W'(MINV) : OUT_W'(w_sh);
            o_sat <= w_hi | w_lo;
        end
    end

endmodule

// File: rtl/cmult_stream.sv
// Streaming 3-multiplier complex multiply p = a*b or a*conj(b),
// 6-stage pipeline, global stall, round/saturate, sticky ovf.
// Ports: clk, rst (async, active-high), bus (cmult_if.slave).
module cmult_stream
    import cmult_pkg::*;
#(
    parameter int AWIDTH    = 16,
    parameter int BWIDTH    = 18,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 17
) (
    input  logic   clk,
    input  logic   rst,
    cmult_if.slave bus
);
    localparam int W = full_width(AWIDTH, BWIDTH);

    if (SHIFT >= W || OUT_WIDTH > W - SHIFT) begin : g_bad_cfg
        $fatal(1, "cmult_stream: SHIFT/OUT_WIDTH do not fit product");
    end

    logic w_ce;
    logic w_xfer_in;
    logic [LAT-1:0] r_v;
    logic [LAT-1:0] r_last;

    assign w_ce      = !r_v[LAT-1] || bus.m_ready;
    assign w_xfer_in = bus.s_valid && w_ce;

    // Valid and frame marker travel alongside the data; bubbles shift too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v    <= '0;
            r_last <= '0;
        end else if (w_ce) begin
            r_v    <= {r_v[LAT-2:0], bus.s_valid};
            r_last <= {r_last[LAT-2:0], bus.s_valid & bus.s_last};
        end
    end

    // Stage 1: inputs, with bi negated for conj in BWIDTH+1 bits.
    logic signed [AWIDTH-1:0] r1_ar, r1_ai;
    logic signed [BWIDTH-1:0] r1_br;
    logic signed [BWIDTH:0]   r1_bi;
    logic signed [BWIDTH:0]   w_bi_x;

    assign w_bi_x = (BWIDTH+1)'(bus.bi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_ar <= '0;
            r1_ai <= '0;
            r1_br <= '0;
            r1_bi <= '0;
        end else if (w_xfer_in) begin
            r1_ar <= bus.ar;
            r1_ai <= bus.ai;
            r1_br <= bus.br;
            r1_bi <= bus.conj ? -w_bi_x : w_bi_x;
        end
    end

    // Stage 2: pre-adds.
    logic signed [AWIDTH:0]   r2_c;
    logic signed [BWIDTH+1:0] r2_dr, r2_di;
    logic signed [BWIDTH:0]   r2_bi;
    logic signed [AWIDTH-1:0] r2_ar, r2_ai;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_c  <= '0;
            r2_dr <= '0;
            r2_di <= '0;
            r2_bi <= '0;
            r2_ar <= '0;
            r2_ai <= '0;
        end else if (w_ce) begin
            r2_c  <= (AWIDTH+1)'(r1_ar) - (AWIDTH+1)'(r1_ai);
            r2_dr <= (BWIDTH+2)'(r1_br) - (BWIDTH+2)'(r1_bi);
            r2_di <= (BWIDTH+2)'(r1_br) + (BWIDTH+2)'(r1_bi);
            r2_bi <= r1_bi;
            r2_ar <= r1_ar;
            r2_ai <= r1_ai;
        end
    end

    // Stage 3: the three shared-term multiplies.
    logic signed [W-1:0] r3_m0, r3_mr, r3_mi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_m0 <= '0;
            r3_mr <= '0;
            r3_mi <= '0;
        end else if (w_ce) begin
            r3_m0 <= W'(r2_c) * W'(r2_bi);
            r3_mr <= W'(r2_dr) * W'(r2_ar);
            r3_mi <= W'(r2_di) * W'(r2_ai);
        end
    end

    // Stage 4: post-adds, exact in W bits.
    logic signed [W-1:0] r4_pr, r4_pi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r4_pr <= '0;
            r4_pi <= '0;
        end else if (w_ce) begin
            r4_pr <= r3_mr + r3_m0;
            r4_pi <= r3_mi + r3_m0;
        end
    end

    // Stages 5-6.
    logic signed [OUT_WIDTH-1:0] w_pr, w_pi;
    logic                        w_sat_r, w_sat_i;

    round_sat #(.IN_W(W), .SHIFT(SHIFT), .OUT_W(OUT_WIDTH)) u_rs_re (
        .i_clk (clk),
        .i_rst (rst),
        .i_ce  (w_ce),
        .i_d   (r4_pr),
        .o_q   (w_pr),
        .o_sat (w_sat_r)
    );

    round_sat #(.IN_W(W), .SHIFT(SHIFT), .OUT_W(OUT_WIDTH)) u_rs_im (
        .i_clk (clk),
        .i_rst (rst),
        .i_ce  (w_ce),
        .i_d   (r4_pi),
        .o_q   (w_pi),
        .o_sat (w_sat_i)
    );

    // Set wins over clear when both happen in the same cycle.
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_v[LAT-1] && bus.m_ready && (w_sat_r || w_sat_i)) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.s_ready = w_ce;
    assign bus.m_valid = r_v[LAT-1];
    assign bus.m_last  = r_last[LAT-1];
    assign bus.pr      = w_pr;
    assign bus.pi      = w_pi;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_cmult_stream.sv
// Testbench for cmult_stream: two configurations (SHIFT=0 wide, defaults),
// randomized streams checked against a plain complex-arithmetic model.
module tb_cmult_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_vec = 0;
    int n_err = 0;
    bit rnd_rdy = 1'b0;

    cmult_if #(.AWIDTH(16), .BWIDTH(18), .OUT_WIDTH(37)) ifa ();
    cmult_if #(.AWIDTH(16), .BWIDTH(18), .OUT_WIDTH(16)) ifb ();

    cmult_stream #(
        .AWIDTH(16), .BWIDTH(18), .OUT_WIDTH(37), .SHIFT(0)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    cmult_stream u_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    typedef struct {
        longint pr;
        longint pi;
        bit     last;
        bit     sat;
        int     cyc;
        bit     lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic longint rsat(input longint v, input int sh,
                                    input int ow, inout bit s);
        longint r;
        longint mx;
        longint mn;
        r  = (sh > 0) ? ((v + (64'sd1 <<< (sh - 1))) >>> sh) : v;
        mx = (64'sd1 <<< (ow - 1)) - 1;
        mn = -mx - 1;
        if (r > mx) begin
            s = 1'b1;
            return mx;
        end
        if (r < mn) begin
            s = 1'b1;
            return mn;
        end
        return r;
    endfunction

    // Direct complex product, then round-half-up and saturate.
    function automatic exp_t model(input longint ar, input longint ai,
                                   input longint br, input longint bi,
                                   input bit cj, input bit last,
                                   input int sh, input int ow);
        exp_t   e;
        longint re;
        longint im;
        bit     s;
        s  = 1'b0;
        re = cj ? (ar * br + ai * bi) : (ar * br - ai * bi);
        im = cj ? (ai * br - ar * bi) : (ar * bi + ai * br);
        e.pr   = rsat(re, sh, ow, s);
        e.pi   = rsat(im, sh, ow, s);
        e.sat  = s;
        e.last = last;
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    function automatic logic signed [15:0] pick_a();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 16'sh8000;
        if (r == 1) return 16'sh7fff;
        return 16'($urandom);
    endfunction

    function automatic logic signed [17:0] pick_b();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 18'sh20000;
        if (r == 1) return 18'sh1ffff;
        return 18'($urandom);
    endfunction

    // which=1 drives the default-config DUT, which=0 the wide one.
    task automatic send(input bit which,
                        input logic signed [15:0] ar,
                        input logic signed [15:0] ai,
                        input logic signed [17:0] br,
                        input logic signed [17:0] bi,
                        input bit cj, input bit last, input bit lat);
        exp_t e;
        bit   done;
        bit   rdy;
        done = 1'b0;
        if (which) begin
            ifb.ar = ar; ifb.ai = ai; ifb.br = br; ifb.bi = bi;
            ifb.conj = cj; ifb.s_last = last; ifb.s_valid = 1'b1;
        end else begin
            ifa.ar = ar; ifa.ai = ai; ifa.br = br; ifa.bi = bi;
            ifa.conj = cj; ifa.s_last = last; ifa.s_valid = 1'b1;
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rdy = which ? ifb.s_ready : ifa.s_ready;
            if (rdy) begin
                e = model(ar, ai, br, bi, cj, last,
                          which ? 17 : 0, which ? 16 : 37);
                e.cyc = cyc;
                e.lat = lat;
                if (which) qb.push_back(e);
                else       qa.push_back(e);
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL s_ready_timeout: dut %0d never accepted", which);
        end
        @(posedge clk);
        #1;
        ifa.s_valid = 1'b0;
        ifb.s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d samples missing",
                     qa.size(), qb.size());
        end
        idle(3);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ifb.m_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin : cmp_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                qa.delete();
            end else if (ifa.m_valid && ifa.m_ready) begin
                if (qa.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_extra: got pr=%0d, expected none",
                             ifa.pr);
                end else begin
                    e = qa.pop_front();
                    check("a_pr", ifa.pr, e.pr);
                    check("a_pi", ifa.pi, e.pi);
                    check("a_last", ifa.m_last, longint'(e.last));
                    if (e.lat) check("a_latency", cyc - e.cyc, 6);
                end
            end
        end
    end

    initial begin : cmp_b
        exp_t e;
        bit   hold;
        bit   mov;
        bit   xs;
        logic signed [15:0] hpr;
        logic signed [15:0] hpi;
        logic hl;
        hold = 1'b0;
        mov  = 1'b0;
        hpr  = '0;
        hpi  = '0;
        hl   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                qb.delete();
                hold = 1'b0;
                mov  = 1'b0;
            end else begin
                xs = 1'b0;
                check("b_ovf", ifb.ovf, longint'(mov));
                if (hold) begin
                    check("hold_valid", ifb.m_valid, 1);
                    check("hold_pr", ifb.pr, hpr);
                    check("hold_pi", ifb.pi, hpi);
                    check("hold_last", ifb.m_last, hl);
                end
                if (ifb.m_valid && ifb.m_ready) begin
                    if (qb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL b_extra: got pr=%0d, expected none",
                                 ifb.pr);
                    end else begin
                        e = qb.pop_front();
                        check("b_pr", ifb.pr, e.pr);
                        check("b_pi", ifb.pi, e.pi);
                        check("b_last", ifb.m_last, longint'(e.last));
                        if (e.lat) check("b_latency", cyc - e.cyc, 6);
                        xs = e.sat;
                    end
                end
                hold = ifb.m_valid && !ifb.m_ready;
                hpr  = ifb.pr;
                hpi  = ifb.pi;
                hl   = ifb.m_last;
                mov  = xs ? 1'b1 : (ifb.ovf_clr ? 1'b0 : mov);
            end
        end
    end

    initial begin : main
        exp_t e;
        ifa.s_valid = 0; ifa.s_last = 0; ifa.conj = 0;
        ifa.ar = 0; ifa.ai = 0; ifa.br = 0; ifa.bi = 0;
        ifa.m_ready = 1; ifa.ovf_clr = 0;
        ifb.s_valid = 0; ifb.s_last = 0; ifb.conj = 0;
        ifb.ar = 0; ifb.ai = 0; ifb.br = 0; ifb.bi = 0;
        ifb.ovf_clr = 0;

        // Hand-computed values pinning the model.
        e = model(3, 4, 5, 6, 0, 0, 0, 37);
        check("pin_t1_re", e.pr, -9);
        check("pin_t1_im", e.pi, 38);
        e = model(3, 4, 5, 6, 1, 0, 0, 37);
        check("pin_conj_re", e.pr, 39);
        check("pin_conj_im", e.pi, 2);
        e = model(-32768, 0, -131072, 0, 0, 0, 17, 16);
        check("pin_sat_re", e.pr, 32767);
        check("pin_sat_flag", e.sat, 1);
        e = model(3, 0, 32768, 0, 0, 0, 17, 16);
        check("pin_rnd_up", e.pr, 1);
        e = model(-2, 0, 32768, 0, 0, 0, 17, 16);
        check("pin_rnd_tie", e.pr, 0);
        e = model(1, 0, 32768, 0, 0, 0, 17, 16);
        check("pin_rnd_q", e.pr, 0);
        e = model(-3, 0, 32768, 0, 0, 0, 17, 16);
        check("pin_rnd_neg", e.pr, -1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_b_mvalid", ifb.m_valid, 0);
        check("rst_b_mlast", ifb.m_last, 0);
        check("rst_b_pr", ifb.pr, 0);
        check("rst_b_pi", ifb.pi, 0);
        check("rst_b_ovf", ifb.ovf, 0);
        check("rst_b_sready", ifb.s_ready, 1);
        check("rst_a_mvalid", ifa.m_valid, 0);
        rst = 1'b0;
        idle(2);

        // Exact products, plain and conjugated.
        send(0, 3, 4, 5, 6, 0, 0, 1);
        drain();
        send(0, 3, 4, 5, 6, 1, 0, 1);
        for (int i = 0; i < 8; i++) send(0, 3, 4, 5, 6, i[0], 0, 0);
        drain();
        for (int i = 0; i < 30; i++) begin
            send(0, pick_a(), pick_a(), pick_b(), pick_b(),
                 1'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Saturation and sticky flag.
        send(1, -32768, 0, -131072, 0, 0, 0, 1);
        drain();
        check("t3_ovf_set", ifb.ovf, 1);
        ifb.ovf_clr = 1'b1;
        idle(1);
        ifb.ovf_clr = 1'b0;
        check("t3_ovf_clr", ifb.ovf, 0);
        ifb.ovf_clr = 1'b1;
        send(1, -32768, 0, -131072, 0, 0, 0, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ifb.m_valid && ifb.m_ready) break;
        end
        @(posedge clk);
        #1;
        ifb.ovf_clr = 1'b0;
        check("t3_set_wins", ifb.ovf, 1);
        drain();

        // Rounding corner cases.
        send(1, 3, 0, 32768, 0, 0, 0, 1);
        send(1, -2, 0, 32768, 0, 0, 0, 1);
        send(1, 1, 0, 32768, 0, 0, 0, 1);
        send(1, -3, 0, 32768, 0, 0, 0, 1);
        drain();

        // 20-sample frame with gaps and random back-pressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(1, pick_a(), pick_a(), pick_b(), pick_b(),
                 1'($urandom), (i == 19), 0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        drain();
        for (int i = 0; i < 150; i++) begin
            send(1, pick_a(), pick_a(), pick_b(), pick_b(),
                 1'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        drain();
        rnd_rdy = 1'b0;
        idle(2);

        // Reset with samples in flight.
        for (int i = 0; i < 5; i++) begin
            send(1, 16'(1000 + i), -7, 18'(200 * i), 5, 0, 0, 0);
        end
        idle(1);
        check("t6_pre_valid", ifb.m_valid, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", ifb.m_valid, 0);
        check("t6_rst_last", ifb.m_last, 0);
        check("t6_rst_pr", ifb.pr, 0);
        check("t6_rst_ovf", ifb.ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        send(1, 100, -200, 3000, -4000, 1, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
